// File: rtl/tone_synth_pkg.sv
// Shared types and constants for the tone_synth DDS tone generator.
package tone_synth_pkg;

  typedef enum logic [1:0] {
    WAVE_SAW    = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SINE   = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    EMIT  = 2'd2
  } state_t;

  localparam int SINE_TABLE_SIZE = 256;
  localparam int SINE_ADDR_W     = $clog2(SINE_TABLE_SIZE);

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int chan_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/tone_sine_lut.sv
// 256 x 8-bit unsigned sine (mid-scale 0x80), built from a quarter-wave table.
// Only compiled when TONE_SYNTH_SINE_EN is defined.
`ifdef TONE_SYNTH_SINE_EN
module tone_sine_lut
  import tone_synth_pkg::*;
(
  input  logic [SINE_ADDR_W-1:0] addr,
  output logic [7:0]             data
);

  logic [6:0] k_s;
  logic [6:0] mag_s;

  function automatic logic [6:0] quarter(input logic [6:0] k);
    logic [6:0] q;
    case (k)
      7'd0:  q = 7'd0;   7'd1:  q = 7'd3;   7'd2:  q = 7'd6;   7'd3:  q = 7'd9;
      7'd4:  q = 7'd12;  7'd5:  q = 7'd16;  7'd6:  q = 7'd19;  7'd7:  q = 7'd22;
      7'd8:  q = 7'd25;  7'd9:  q = 7'd28;  7'd10: q = 7'd31;  7'd11: q = 7'd34;
      7'd12: q = 7'd37;  7'd13: q = 7'd40;  7'd14: q = 7'd43;  7'd15: q = 7'd46;
      7'd16: q = 7'd49;  7'd17: q = 7'd51;  7'd18: q = 7'd54;  7'd19: q = 7'd57;
      7'd20: q = 7'd60;  7'd21: q = 7'd63;  7'd22: q = 7'd65;  7'd23: q = 7'd68;
      7'd24: q = 7'd71;  7'd25: q = 7'd73;  7'd26: q = 7'd76;  7'd27: q = 7'd78;
      7'd28: q = 7'd81;  7'd29: q = 7'd83;  7'd30: q = 7'd85;  7'd31: q = 7'd88;
      7'd32: q = 7'd90;  7'd33: q = 7'd92;  7'd34: q = 7'd94;  7'd35: q = 7'd96;
      7'd36: q = 7'd98;  7'd37: q = 7'd100; 7'd38: q = 7'd102; 7'd39: q = 7'd104;
      7'd40: q = 7'd106; 7'd41: q = 7'd107; 7'd42: q = 7'd109; 7'd43: q = 7'd111;
      7'd44: q = 7'd112; 7'd45: q = 7'd113; 7'd46: q = 7'd115; 7'd47: q = 7'd116;
      7'd48: q = 7'd117; 7'd49: q = 7'd118; 7'd50: q = 7'd120; 7'd51: q = 7'd121;
      7'd52: q = 7'd122; 7'd53: q = 7'd122; 7'd54: q = 7'd123; 7'd55: q = 7'd124;
      7'd56: q = 7'd125; 7'd57: q = 7'd125; 7'd58: q = 7'd126; 7'd59: q = 7'd126;
      7'd60: q = 7'd126; 7'd61: q = 7'd127; 7'd62: q = 7'd127; 7'd63: q = 7'd127;
      7'd64: q = 7'd127;
      default: q = 7'd127;
    endcase
    return q;
  endfunction

  // Odd quadrants mirror the index, the upper half mirrors the amplitude.
  always_comb begin
    if (addr[6]) begin
      k_s = 7'd64 - {1'b0, addr[5:0]};
    end else begin
      k_s = {1'b0, addr[5:0]};
    end
    mag_s = quarter(k_s);
    if (addr[7]) begin
      data = 8'd128 - {1'b0, mag_s};
    end else begin
      data = 8'd128 + {1'b0, mag_s};
    end
  end

endmodule
`endif

// File: rtl/tone_synth.sv
// Time-multiplexed multi-channel DDS tone generator with an averaging mixer.
// Define TONE_SYNTH_SINE_EN to enable the sine table for wave code 3 (else code 3 = triangle).
module tone_synth
  import tone_synth_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int PHASE_W    = 24,
  parameter int OUT_W      = 8,
  parameter int SAMPLE_DIV = 47
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [chan_w(CHANNELS)-1:0]   cfg_chan,
  input  logic [PHASE_W-1:0]            cfg_ftw,
  input  logic [1:0]                    cfg_wave,
  input  logic                          cfg_en,
  input  logic                          cfg_phase_rst,
  output logic [OUT_W-1:0]              sample,
  output logic                          sample_valid
);

  localparam int CH_W   = chan_w(CHANNELS);
  localparam int MIX_SH = $clog2(CHANNELS);
  localparam int ACC_W  = OUT_W + MIX_SH;
  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [DIV_W-1:0]   div_q, div_d;
  state_t             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]   sample_q, sample_d;
  logic               valid_q, valid_d;
  logic [PHASE_W-1:0] phase_q [CHANNELS];
  logic [PHASE_W-1:0] phase_d [CHANNELS];
  logic [PHASE_W-1:0] ftw_q   [CHANNELS];
  logic [PHASE_W-1:0] ftw_d   [CHANNELS];
  wave_t              wave_q  [CHANNELS];
  wave_t              wave_d  [CHANNELS];
  logic               en_q    [CHANNELS];
  logic               en_d    [CHANNELS];

  logic               tick_s;
  logic               chan_ok_s;
  logic [PHASE_W-1:0] new_phase_s;
  logic [OUT_W-1:0]   p_s;
  logic [OUT_W-1:0]   tri_s;
  logic [OUT_W-1:0]   wave_val_s;

  assign tick_s      = (div_q == DIV_W'(SAMPLE_DIV - 1));
  assign chan_ok_s   = ({1'b0, cfg_chan} < (CH_W + 1)'(CHANNELS));
  assign new_phase_s = phase_q[ch_q] + ftw_q[ch_q];
  assign p_s         = new_phase_s[PHASE_W-1 -: OUT_W];
  assign tri_s       = {p_s[OUT_W-2:0], 1'b0};
  assign cfg_ready   = (state_q == IDLE);
  assign sample      = sample_q;
  assign sample_valid = valid_q;

`ifdef TONE_SYNTH_SINE_EN
  logic [7:0] sine_s;

  tone_sine_lut u_sine (
    .addr (new_phase_s[PHASE_W-1 -: SINE_ADDR_W]),
    .data (sine_s)
  );
`endif

  // Waveform value of the channel under sweep, from its post-increment phase.
  always_comb begin
    wave_val_s = p_s;
    case (wave_q[ch_q])
      WAVE_SAW:    wave_val_s = p_s;
      WAVE_SQUARE: wave_val_s = {OUT_W{new_phase_s[PHASE_W-1]}};
      WAVE_TRI:    wave_val_s = new_phase_s[PHASE_W-1] ? ~tri_s : tri_s;
      WAVE_SINE: begin
`ifdef TONE_SYNTH_SINE_EN
        wave_val_s = OUT_W'(sine_s) << (OUT_W - 8);
`else
        wave_val_s = new_phase_s[PHASE_W-1] ? ~tri_s : tri_s;
`endif
      end
      default:     wave_val_s = p_s;
    endcase
  end

  // Divider, config writes and the IDLE/SWEEP/EMIT sequencer.
  always_comb begin
    div_d    = tick_s ? DIV_W'(0) : div_q + DIV_W'(1);
    state_d  = state_q;
    ch_d     = ch_q;
    acc_d    = acc_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    phase_d  = phase_q;
    ftw_d    = ftw_q;
    wave_d   = wave_q;
    en_d     = en_q;
    case (state_q)
      IDLE: begin
        // Writes to nonexistent channels are accepted but dropped.
        if (cfg_valid && chan_ok_s) begin
          ftw_d[cfg_chan]  = cfg_ftw;
          wave_d[cfg_chan] = wave_t'(cfg_wave);
          en_d[cfg_chan]   = cfg_en;
          if (cfg_phase_rst) begin
            phase_d[cfg_chan] = '0;
          end else begin
            phase_d[cfg_chan] = phase_q[cfg_chan];
          end
        end else begin
          en_d = en_q;
        end
        if (tick_s) begin
          state_d = SWEEP;
          ch_d    = '0;
          acc_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SWEEP: begin
        if (en_q[ch_q]) begin
          phase_d[ch_q] = new_phase_s;
          acc_d         = acc_q + ACC_W'(wave_val_s);
        end else begin
          acc_d = acc_q;
        end
        if (ch_q == CH_W'(CHANNELS - 1)) begin
          state_d = EMIT;
          valid_d = 1'b1;
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
      EMIT: begin
        sample_d = OUT_W'(acc_q >> MIX_SH);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      state_q  <= IDLE;
      ch_q     <= '0;
      acc_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      phase_q  <= '{default: '0};
      ftw_q    <= '{default: '0};
      wave_q   <= '{default: WAVE_SAW};
      en_q     <= '{default: 1'b0};
    end else begin
      div_q    <= div_d;
      state_q  <= state_d;
      ch_q     <= ch_d;
      acc_q    <= acc_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      phase_q  <= phase_d;
      ftw_q    <= ftw_d;
      wave_q   <= wave_d;
      en_q     <= en_d;
    end
  end

endmodule

// File: tb/tb_tone_synth.sv
// Self-checking bench for tone_synth: per-sample behavioural model plus directed literal vectors.
module tb_tone_synth;

  localparam int CH = 2;
  localparam int PW = 16;
  localparam int OW = 8;
  localparam int SD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [0:0]  cfg_chan = 1'b0;
  logic [15:0] cfg_ftw = 16'h0000;
  logic [1:0]  cfg_wave = 2'd0;
  logic        cfg_en = 1'b0;
  logic        cfg_phase_rst = 1'b0;
  logic [7:0]  sample;
  logic        sample_valid;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  tone_synth #(.CHANNELS(CH), .PHASE_W(PW), .OUT_W(OW), .SAMPLE_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_ftw(cfg_ftw), .cfg_wave(cfg_wave), .cfg_en(cfg_en),
    .cfg_phase_rst(cfg_phase_rst), .sample(sample), .sample_valid(sample_valid)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Waveform value straight from the waveform definitions (16-bit phase, 8-bit output).
  function automatic int wave_value(input int wave, input int phase);
    int p = (phase >> 8) & 255;
    int tv = (p * 2) % 256;
    if (p >= 128) tv = 255 - tv;
    case (wave)
      0: return p;
      1: return (p >= 128) ? 255 : 0;
      2: return tv;
      default: begin
`ifdef TONE_SYNTH_SINE_EN
        return 128 + int'(127.0 * $sin(2.0 * 3.141592653589793 * real'(p) / 256.0));
`else
        return tv;
`endif
      end
    endcase
  endfunction

  // Model state: per-channel config/phase plus sample-period bookkeeping.
  int m_ftw[CH], m_wave[CH], m_en[CH], m_phase[CH];
  int m_exp_sample = 0, m_pending = 0, m_last_tick = 0, m_cyc = 0;
  bit m_have_tick = 0, m_in_reset = 1;

  initial forever begin
    bit busy;
    int acc;
    @(negedge clk);
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        m_ftw[c] = 0; m_wave[c] = 0; m_en[c] = 0; m_phase[c] = 0;
      end
      m_exp_sample = 0; m_have_tick = 0; m_in_reset = 1; m_cyc = 0;
      check("reset_sample", int'(sample), 0);
      check("reset_valid", int'(sample_valid), 0);
    end else begin
      if (m_in_reset) begin
        m_in_reset = 0;
        m_cyc = 1;
      end
      busy = m_have_tick && (m_cyc - m_last_tick >= 1) && (m_cyc - m_last_tick <= 3);
      check("cfg_ready", int'(cfg_ready), int'(!busy));
      check("sample_valid", int'(sample_valid), int'(m_have_tick && (m_cyc - m_last_tick == 3)));
      check("sample", int'(sample), m_exp_sample);
      if (cfg_valid && !busy) begin
        m_ftw[cfg_chan] = int'(cfg_ftw);
        m_wave[cfg_chan] = int'(cfg_wave);
        m_en[cfg_chan] = int'(cfg_en);
        if (cfg_phase_rst) m_phase[cfg_chan] = 0;
      end
      if (m_have_tick && (m_cyc - m_last_tick == 3)) m_exp_sample = m_pending;
      if (m_cyc % SD == SD - 1) begin
        acc = 0;
        for (int c = 0; c < CH; c++) begin
          if (m_en[c] != 0) begin
            m_phase[c] = (m_phase[c] + m_ftw[c]) % 65536;
            acc += wave_value(m_wave[c], m_phase[c]);
          end
        end
        m_pending = acc / CH;
        m_last_tick = m_cyc;
        m_have_tick = 1;
      end
      m_cyc++;
    end
  end

  task automatic release_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Caller sits just after a rising edge; returns just after the accepting edge.
  task automatic cfg_write(input int ch, input int ftw, input int wave, input int en, input int prst);
    int waited = 0;
    cfg_chan = 1'(ch); cfg_ftw = 16'(ftw); cfg_wave = 2'(wave);
    cfg_en = 1'(en); cfg_phase_rst = 1'(prst); cfg_valid = 1'b1;
    @(negedge clk);
    while (!cfg_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cfg_ready) timeout("cfg_accept");
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    ok = 0;
    while (n < 40 && !ok) begin
      @(negedge clk);
      if (sample_valid) ok = 1;
      n++;
    end
    if (!ok) timeout("wait_sample_valid");
  endtask

  task automatic expect_next(input string name, input int exp);
    bit ok;
    wait_valid(ok);
    @(negedge clk);
    if (ok) check(name, int'(sample), exp);
  endtask

  // Leaves the bench just after the edge that starts the first IDLE cycle after EMIT.
  task automatic align();
    bit ok;
    wait_valid(ok);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses, first_pulse, lows;
    int sq[6]  = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF};
    int tr[4]  = '{8'h40, 8'h7F, 8'h3F, 8'h00};
`ifdef TONE_SYNTH_SINE_EN
    int w3[4]  = '{8'h7F, 8'h40, 8'h00, 8'h40};
`else
    int w3[4]  = '{8'h40, 8'h7F, 8'h3F, 8'h00};
`endif
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    release_reset();

    // Idle: pulses at cycles 10, 18, 26, 34 after release.
    pulses = 0; first_pulse = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        pulses++;
        if (first_pulse == 0) first_pulse = i;
      end
    end
    check("idle_pulse_count", pulses, 4);
    check("idle_first_pulse_cycle", first_pulse, 10);

    // Saw on ch0: 0x08, 0x10, ... wrapping to 0x00 on the 16th sample.
    @(posedge clk); #1;
    cfg_write(0, 16'h1000, 0, 1, 1);
    for (int i = 1; i <= 16; i++) expect_next($sformatf("saw_%0d", i), ((i * 16) % 256) / 2);

    // Two squares in phase.
    align();
    cfg_write(0, 16'h4000, 1, 1, 1);
    cfg_write(1, 16'h4000, 1, 1, 1);
    for (int i = 0; i < 6; i++) expect_next($sformatf("square_%0d", i), sq[i]);

    // Triangle on ch0 only, halved by the mixer.
    align();
    cfg_write(0, 16'h4000, 2, 1, 1);
    cfg_write(1, 16'h0000, 0, 0, 1);
    for (int i = 0; i < 4; i++) expect_next($sformatf("tri_%0d", i), tr[i]);

    // Wave code 3.
    align();
    cfg_write(0, 16'h4000, 3, 1, 1);
    for (int i = 0; i < 4; i++) expect_next($sformatf("wave3_%0d", i), w3[i]);

    // Hold cfg_valid from the tick edge: three not-ready cycles, then accepted.
    align();
    repeat (5) @(posedge clk);
    #1;
    cfg_chan = 1'b0; cfg_ftw = 16'h1000; cfg_wave = 2'd0; cfg_en = 1'b1;
    cfg_phase_rst = 1'b1; cfg_valid = 1'b1;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cfg_ready) break;
      lows++;
    end
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    check("ready_low_cycles", lows, 3);
    expect_next("held_write_next_sample", 8'h08);

    // Reset in the second sweep cycle: no pulse for the aborted sample.
    align();
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midsweep_rst_sample", int'(sample), 0);
    check("midsweep_rst_valid", int'(sample_valid), 0);
    @(negedge clk);
    release_reset();
    @(negedge clk);
    check("ready_after_release", int'(cfg_ready), 1);
    check("sample_after_release", int'(sample), 0);
    pulses = int'(sample_valid);
    repeat (8) begin
      @(negedge clk);
      if (sample_valid) pulses++;
    end
    check("no_pulse_after_abort", pulses, 0);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
